audio_sample_feeder: RTL

//  Downstream stage of the triangle-wave mixer: samples the 32-bit signed summed note output at the

---
 rtl/audio_pkg.sv | 38 +++
 rtl/sample_rate_tick.sv | 27 ++
 rtl/audio_sample_feeder.sv | 99 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions: feeder state encoding and the saturating gain shift
// used by the feeder and the upcoming voice/mixer stages.
package audio_pkg;

    localparam int CLK_DIV_DEFAULT = 1042;
    localparam int SAT_W           = 128;

    typedef enum logic [0:0] {IDLE, PEND} feeder_state_e;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] val;
    } sat_res_t;

    // Callers sign-extend into 'in'; the result is clamped to a signed out_w-bit range.
    function automatic sat_res_t sat_shift(input logic signed [63:0] in,
                                           input int unsigned        sh,
                                           input int unsigned        out_w);
        logic signed [SAT_W-1:0] ext;
        logic signed [SAT_W-1:0] shifted;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                r;
        ext     = SAT_W'(in);
        shifted = ext <<< sh;
        hi      = (128'sd1 <<< (out_w - 1)) - 128'sd1;
        lo      = -hi - 128'sd1;
        r.sat   = (shifted > hi) || (shifted < lo);
        if (shifted > hi)
            r.val = hi;
        else if (shifted < lo)
            r.val = lo;
        else
            r.val = shifted;
        return r;
    endfunction

endpackage

// File: rtl/sample_rate_tick.sv
// Free-running divider: one-cycle tick every CLK_DIV clocks, first tick CLK_DIV cycles after reset.
module sample_rate_tick
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(CLK_DIV - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (tick)
            cnt_q <= '0;
        else
            cnt_q <= cnt_q + 1'b1;
    end

endmodule

// File: rtl/audio_sample_feeder.sv
// Samples the mixer output at the codec rate, applies gain/mute with saturation and
// hands identical L/R samples to the codec FIFO; tracks clipping and dropped samples.
module audio_sample_feeder
    import audio_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT,
    parameter int IN_W    = 32,
    parameter int OUT_W   = 32,
    parameter int GAIN_W  = 3,
    parameter int OVR_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IN_W-1:0]   mix_in,
    input  logic [GAIN_W-1:0] gain,
    input  logic              mute,
    input  logic              audio_out_allowed,
    output logic              write_audio_out,
    output logic [OUT_W-1:0]  left_channel_audio_out,
    output logic [OUT_W-1:0]  right_channel_audio_out,
    input  logic              clip_clear,
    output logic              clip,
    output logic [OVR_W-1:0]  overrun_count
);

    logic          tick;
    feeder_state_e state_q, state_d;
    logic          capture;
    logic          overrun;
    logic [OUT_W-1:0] sample_q;
    logic [OUT_W-1:0] cap_val;
    logic          cap_clip;
    logic          clip_q;
    logic [OVR_W-1:0] ovr_q;
    sat_res_t      res;
    logic          unused_hi;

    sample_rate_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign res       = sat_shift(64'(signed'(mix_in)), 32'(gain), 32'(OUT_W));
    assign unused_hi = ^res.val[SAT_W-1:OUT_W];
    assign cap_val   = mute ? '0 : res.val[OUT_W-1:0];
    assign cap_clip  = !mute && res.sat;

    always_comb begin
        state_d         = state_q;
        capture         = 1'b0;
        overrun         = 1'b0;
        write_audio_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                // The held sample goes out this cycle even if a new one is captured at the edge.
                write_audio_out = audio_out_allowed;
                if (tick) begin
                    capture = 1'b1;
                    overrun = !audio_out_allowed;
                end else if (audio_out_allowed) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sample_q <= '0;
            clip_q   <= 1'b0;
            ovr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (capture)
                sample_q <= cap_val;
            if (capture && cap_clip)
                clip_q <= 1'b1;
            else if (clip_clear)
                clip_q <= 1'b0;
            if (overrun && (ovr_q != '1))
                ovr_q <= ovr_q + 1'b1;
        end
    end

    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign clip                    = clip_q;
    assign overrun_count           = ovr_q;

endmodule
